aes_campaign_ctrl: RTL and testbench

- Synthesizable campaign sequencer sitting between a fault-injection controller and the Custom_AES core.
- Loads a key and seed plaintext, then runs N chained encryptions, feeding each Dout back as the next Din.
- Compares every ciphertext against an externally stored expected value and tags each run with a fault mode (N/F1/F0).
- Reports per-run mismatch counts and status for glitch/fault experiments.

---
 rtl/aes_campaign_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_aes_campaign_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_campaign_ctrl.sv
// Campaign sequencer: loads key/seed into a Custom_AES core, runs N chained encryptions
// and scores each ciphertext against an external expected-value memory (AES_TRACE_EN adds first-mismatch trace).
module aes_campaign_ctrl #(
    parameter int DATA_W    = 128,
    parameter int ITER_W    = 10,
    parameter int KDRDY_CYC = 2,
    parameter int TMO_CYC   = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ITER_W-1:0] n_iter,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] seed,
    input  logic [1:0]        fault_mode,
    output logic              aes_en,
    output logic [DATA_W-1:0] aes_kin,
    output logic [DATA_W-1:0] aes_din,
    output logic              aes_kdrdy,
    input  logic [DATA_W-1:0] aes_dout,
    input  logic              aes_dvld,
    output logic [ITER_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [ITER_W-1:0] mis_cnt,
    output logic [1:0]        fault_tag,
    output logic              tmo_flag
`ifdef AES_TRACE_EN
    ,
    output logic [ITER_W-1:0] mis_first,
    output logic              mis_seen
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_CHAIN = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int KW = (KDRDY_CYC > 1) ? $clog2(KDRDY_CYC) : 1;
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] dout_q;
    logic [ITER_W-1:0] n_iter_q, n_iter_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] mis_q, mis_d;
    logic [ITER_W-1:0] iter_inc;
    logic [1:0]        tag_q, tag_d;
    logic              tmo_q, tmo_d;
    logic [KW-1:0]     kcnt_q, kcnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
`ifdef AES_TRACE_EN
    logic [ITER_W-1:0] first_q, first_d;
    logic              seen_q, seen_d;
`endif

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign iter_inc = iter_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        din_d    = din_q;
        n_iter_d = n_iter_q;
        iter_d   = iter_q;
        mis_d    = mis_q;
        tag_d    = tag_q;
        tmo_d    = tmo_q;
        kcnt_d   = kcnt_q;
        tcnt_d   = tcnt_q;
`ifdef AES_TRACE_EN
        first_d  = first_q;
        seen_d   = seen_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    iter_d = '0;
                    mis_d  = '0;
                    tmo_d  = 1'b0;
                    tag_d  = fault_mode;
`ifdef AES_TRACE_EN
                    first_d = '0;
                    seen_d  = 1'b0;
`endif
                    if (n_iter != '0) begin
                        key_d    = key;
                        din_d    = seed;
                        n_iter_d = n_iter;
                        kcnt_d   = '0;
                        state_d  = S_LOAD;
                    end else begin
                        state_d  = S_FIN;
                    end
                end
            end
            S_LOAD: begin
                if (kcnt_q == KW'(KDRDY_CYC - 1)) begin
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    kcnt_d = kcnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (aes_dvld) begin
                    state_d = S_CHECK;
                end else if (tcnt_q == TW'(TMO_CYC - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                iter_d = iter_inc;
                if (dout_q != exp_data) begin
                    mis_d = sat_inc(mis_q);
`ifdef AES_TRACE_EN
                    if (!seen_q) begin
                        first_d = iter_q;
                        seen_d  = 1'b1;
                    end
`endif
                end
                state_d = (iter_inc == n_iter_q) ? S_FIN : S_CHAIN;
            end
            // exp_addr already tracks the new iter_cnt here, giving memory a cycle before the next CHECK
            S_CHAIN: begin
                din_d   = dout_q;
                kcnt_d  = '0;
                state_d = S_LOAD;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            din_q    <= '0;
            n_iter_q <= '0;
            iter_q   <= '0;
            mis_q    <= '0;
            tag_q    <= '0;
            tmo_q    <= 1'b0;
            kcnt_q   <= '0;
            tcnt_q   <= '0;
`ifdef AES_TRACE_EN
            first_q  <= '0;
            seen_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            din_q    <= din_d;
            n_iter_q <= n_iter_d;
            iter_q   <= iter_d;
            mis_q    <= mis_d;
            tag_q    <= tag_d;
            tmo_q    <= tmo_d;
            kcnt_q   <= kcnt_d;
            tcnt_q   <= tcnt_d;
`ifdef AES_TRACE_EN
            first_q  <= first_d;
            seen_q   <= seen_d;
`endif
        end
    end

    // Ciphertext holding register is pure datapath and needs no reset.
    always_ff @(posedge CLK) begin
        if (state_q == S_WAIT && aes_dvld) begin
            dout_q <= aes_dout;
        end
    end

    assign busy      = (state_q == S_LOAD) || (state_q == S_WAIT) ||
                       (state_q == S_CHECK) || (state_q == S_CHAIN);
    assign aes_en    = busy;
    assign aes_kdrdy = (state_q == S_LOAD);
    assign done      = (state_q == S_FIN);
    assign aes_kin   = key_q;
    assign aes_din   = din_q;
    assign exp_addr  = iter_q;
    assign iter_cnt  = iter_q;
    assign mis_cnt   = mis_q;
    assign fault_tag = tag_q;
    assign tmo_flag  = tmo_q;
`ifdef AES_TRACE_EN
    assign mis_first = first_q;
    assign mis_seen  = seen_q;
`endif

endmodule

// File: tb/tb_aes_campaign_ctrl.sv
// Bench for aes_campaign_ctrl: behavioural AES-128 core, 1-cycle expected memory and a chain reference model.
module tb_aes_campaign_ctrl;
    localparam int DATA_W = 128, ITER_W = 10, KDRDY_CYC = 2, TMO_CYC = 64;

    logic CLK = 1'b0, RST = 1'b1, start = 1'b0;
    logic [ITER_W-1:0] n_iter = '0;
    logic [DATA_W-1:0] key = '0, seed = '0, aes_dout = '0, exp_data = '0;
    logic [1:0] fault_mode = '0;
    logic aes_dvld = 1'b0;
    logic aes_en, aes_kdrdy, busy, done, tmo_flag;
    logic [DATA_W-1:0] aes_kin, aes_din;
    logic [ITER_W-1:0] exp_addr, iter_cnt, mis_cnt;
    logic [1:0] fault_tag;
`ifdef AES_TRACE_EN
    logic [ITER_W-1:0] mis_first;
    logic mis_seen;
`endif

    aes_campaign_ctrl #(.DATA_W(DATA_W), .ITER_W(ITER_W), .KDRDY_CYC(KDRDY_CYC), .TMO_CYC(TMO_CYC)) dut (
        .CLK(CLK), .RST(RST), .start(start), .n_iter(n_iter), .key(key), .seed(seed),
        .fault_mode(fault_mode), .aes_en(aes_en), .aes_kin(aes_kin), .aes_din(aes_din),
        .aes_kdrdy(aes_kdrdy), .aes_dout(aes_dout), .aes_dvld(aes_dvld), .exp_addr(exp_addr),
        .exp_data(exp_data), .busy(busy), .done(done), .iter_cnt(iter_cnt), .mis_cnt(mis_cnt),
        .fault_tag(fault_tag), .tmo_flag(tmo_flag)
`ifdef AES_TRACE_EN
        , .mis_first(mis_first), .mis_seen(mis_seen)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0, checks = 0;
    logic [7:0] sbox [256];
    logic [127:0] exp_mem [1024];
    logic [127:0] mdl_din [64];
    logic [127:0] din_log [$];
    int core_lat = 3, loads = 0, kd_run = 0, kd_bad = 0;
    bit core_rand = 0, stall = 0, spur = 0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, r1, r2, r3, r4;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
            sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [31:0] tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Reference: the true ciphertext chain from seed, scored against exp_mem.
    function automatic int model_mis(input logic [127:0] k, input logic [127:0] s, input int n, output int first);
        logic [127:0] x, y;
        int mis;
        mis = 0; first = -1; x = s;
        for (int i = 0; i < n; i++) begin
            mdl_din[i] = x;
            y = aes_enc(k, x);
            if (y !== exp_mem[i]) begin
                mis++;
                if (first < 0) first = i;
            end
            x = y;
        end
        return mis;
    endfunction

    task automatic fill_exp(input logic [127:0] k, input logic [127:0] s, input int n, input int flip_pct);
        logic [127:0] x;
        x = s;
        for (int i = 0; i < n; i++) begin
            x = aes_enc(k, x);
            exp_mem[i] = ($urandom_range(0, 99) < flip_pct) ? (x ^ (128'h1 << $urandom_range(0, 127))) : x;
        end
    endtask

    // Core model + expected memory, driven on the falling edge.
    initial begin
        logic [127:0] kc, dc;
        logic [ITER_W-1:0] addr_prev;
        int cnt;
        bit pend;
        kc = '0; dc = '0; addr_prev = '0; cnt = 0; pend = 0;
        forever begin
            @(negedge CLK);
            exp_data = exp_mem[addr_prev];
            addr_prev = exp_addr;
            aes_dvld = 1'b0;
            if (aes_kdrdy) begin
                if (kd_run == 0) begin
                    din_log.push_back(aes_din);
                    loads++;
                end
                kd_run++;
                kc = aes_kin; dc = aes_din; pend = 1;
                cnt = core_rand ? int'($urandom_range(0, 12)) : core_lat;
                if (spur) begin
                    aes_dvld = 1'b1;
                    aes_dout = {$urandom, $urandom, $urandom, $urandom};
                end
            end else begin
                if (kd_run != 0 && kd_run != KDRDY_CYC) kd_bad++;
                kd_run = 0;
                if (RST) pend = 0;
                else if (pend && !stall) begin
                    if (cnt == 0) begin
                        aes_dvld = 1'b1;
                        aes_dout = aes_enc(kc, dc);
                        pend = 0;
                    end else cnt--;
                end
            end
        end
    end

    task automatic run(input logic [127:0] k, input logic [127:0] s, input int n, input logic [1:0] fm,
                       input int budget, output bit got_done);
        int cyc;
        @(negedge CLK);
        key = k; seed = s; n_iter = ITER_W'(n); fault_mode = fm; start = 1'b1;
        din_log.delete(); loads = 0; kd_bad = 0;
        @(negedge CLK);
        start = 1'b0;
        got_done = 0; cyc = 0;
        while (!got_done && cyc < budget) begin
            if (done) got_done = 1;
            else begin
                @(negedge CLK);
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++; if ({busy, done, aes_en, aes_kdrdy, tmo_flag} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, aes_en, aes_kdrdy, tmo_flag}); end
        checks++; if (aes_kin !== '0 || aes_din !== '0) begin errors++; $display("FAIL reset_data: kin=%h din=%h want 0", aes_kin, aes_din); end
        checks++; if ({exp_addr, iter_cnt, mis_cnt, fault_tag} !== '0) begin errors++; $display("FAIL reset_cnt: addr=%0d iter=%0d mis=%0d tag=%0d want 0", exp_addr, iter_cnt, mis_cnt, fault_tag); end
        RST = 1'b0;
    endtask

    task automatic test_fips();
        bit ok;
        core_rand = 0; core_lat = 3; spur = 0;
        exp_mem[0] = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
        run(128'h000102030405060708090A0B0C0D0E0F, 128'h00112233445566778899AABBCCDDEEFF, 1, 2'd0, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fips_done: no done pulse within budget"); end
        checks++; if (loads !== 1 || kd_bad !== 0) begin errors++; $display("FAIL fips_kdrdy: loads=%0d bad_len=%0d want 1/0", loads, kd_bad); end
        checks++; if (din_log.size() < 1 || din_log[0] !== 128'h00112233445566778899AABBCCDDEEFF) begin errors++; $display("FAIL fips_din: log size %0d first din wrong", din_log.size()); end
        checks++; if (iter_cnt !== 10'd1 || mis_cnt !== 10'd0 || fault_tag !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL fips_result: iter=%0d mis=%0d tag=%0d busy=%b want 1/0/0/0", iter_cnt, mis_cnt, fault_tag, busy); end
        @(negedge CLK);
        checks++; if (done !== 1'b0 || iter_cnt !== 10'd1) begin errors++; $display("FAIL fips_pulse: done=%b iter=%0d want 0/1", done, iter_cnt); end
    endtask

    task automatic test_chain();
        bit ok;
        int mis, first, bad;
        logic [127:0] k, s;
        k = 128'h000102030405060708090A0B0C0D0E0F; s = 128'h00112233445566778899AABBCCDDEEFF;
        fill_exp(k, s, 5, 0);
        mis = model_mis(k, s, 5, first);
        run(k, s, 5, 2'd0, 400, ok);
        bad = 0;
        for (int i = 0; i < 5; i++) if (i >= din_log.size() || din_log[i] !== mdl_din[i]) bad++;
        checks++; if (!ok) begin errors++; $display("FAIL chain_done: no done pulse within budget"); end
        checks++; if (bad != 0 || din_log.size() != 5) begin errors++; $display("FAIL chain_din: %0d wrong of %0d loads, want 0 of 5", bad, din_log.size()); end
        checks++; if (iter_cnt !== 10'd5 || mis_cnt !== ITER_W'(mis)) begin errors++; $display("FAIL chain_result: iter=%0d mis=%0d want 5/%0d", iter_cnt, mis_cnt, mis); end
    endtask

    task automatic test_corrupt();
        bit ok;
        int mis, first;
        logic [127:0] k, s;
        k = 128'h000102030405060708090A0B0C0D0E0F; s = 128'h00112233445566778899AABBCCDDEEFF;
        fill_exp(k, s, 5, 0);
        exp_mem[2][0] = ~exp_mem[2][0];
        mis = model_mis(k, s, 5, first);
        run(k, s, 5, 2'd1, 400, ok);
        checks++; if (!ok || iter_cnt !== 10'd5) begin errors++; $display("FAIL corrupt_iter: done=%b iter=%0d want 1/5", ok, iter_cnt); end
        checks++; if (mis_cnt !== ITER_W'(mis) || fault_tag !== 2'd1) begin errors++; $display("FAIL corrupt_mis: mis=%0d tag=%0d want %0d/1", mis_cnt, fault_tag, mis); end
`ifdef AES_TRACE_EN
        checks++; if (mis_first !== ITER_W'(first) || mis_seen !== 1'b1) begin errors++; $display("FAIL corrupt_trace: first=%0d seen=%b want %0d/1", mis_first, mis_seen, first); end
`endif
    endtask

    task automatic test_timeout();
        int c;
        stall = 1; core_rand = 0;
        @(negedge CLK);
        key = 128'h1; seed = 128'h2; n_iter = 10'd3; fault_mode = 2'd2; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        c = 0;
        while (!aes_kdrdy && c < 10) begin @(negedge CLK); c++; end
        while (aes_kdrdy && c < 20) begin @(negedge CLK); c++; end
        checks++; if (c >= 20 || busy !== 1'b1) begin errors++; $display("FAIL tmo_wait_entry: cycles=%0d busy=%b", c, busy); end
        repeat (TMO_CYC - 1) @(negedge CLK);
        checks++; if (tmo_flag !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early: tmo=%b busy=%b want 0/1", tmo_flag, busy); end
        @(negedge CLK);
        checks++; if (tmo_flag !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || aes_en !== 1'b0 || iter_cnt !== 10'd0) begin errors++; $display("FAIL tmo_fire: tmo=%b done=%b busy=%b en=%b iter=%0d want 1/1/0/0/0", tmo_flag, done, busy, aes_en, iter_cnt); end
        @(negedge CLK);
        checks++; if (tmo_flag !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL tmo_sticky: tmo=%b done=%b want 1/0", tmo_flag, done); end
        stall = 0;
    endtask

    task automatic test_rst_mid();
        bit ok, prev;
        int falls, c, mis, first;
        logic [127:0] k, s;
        core_rand = 0; core_lat = 6;
        k = {$urandom, $urandom, $urandom, $urandom}; s = {$urandom, $urandom, $urandom, $urandom};
        fill_exp(k, s, 5, 0);
        @(negedge CLK);
        key = k; seed = s; n_iter = 10'd5; fault_mode = 2'd3; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        falls = 0; c = 0; prev = aes_kdrdy;
        while (falls < 3 && c < 300) begin
            @(negedge CLK); c++;
            if (prev && !aes_kdrdy) falls++;
            prev = aes_kdrdy;
        end
        checks++; if (falls != 3 || iter_cnt !== 10'd2 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_reach: loads=%0d iter=%0d busy=%b want 3/2/1", falls, iter_cnt, busy); end
        RST = 1'b1;
        @(negedge CLK);
        checks++; if ({busy, done, aes_en, aes_kdrdy, tmo_flag, exp_addr, iter_cnt, mis_cnt, fault_tag} !== '0 || aes_kin !== '0 || aes_din !== '0) begin errors++; $display("FAIL rstmid_clear: busy=%b kdrdy=%b iter=%0d tag=%0d kin=%h", busy, aes_kdrdy, iter_cnt, fault_tag, aes_kin); end
        RST = 1'b0;
        fill_exp(k, s, 2, 0);
        mis = model_mis(k, s, 2, first);
        run(k, s, 2, 2'd0, 300, ok);
        checks++; if (!ok || iter_cnt !== 10'd2 || mis_cnt !== ITER_W'(mis)) begin errors++; $display("FAIL rstmid_rerun: done=%b iter=%0d mis=%0d want 1/2/%0d", ok, iter_cnt, mis_cnt, mis); end
    endtask

    task automatic test_zero_and_busy();
        int c;
        logic [127:0] k1;
        @(negedge CLK);
        n_iter = 10'd0; fault_mode = 2'd2; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || aes_kdrdy !== 1'b0 || iter_cnt !== 10'd0 || mis_cnt !== 10'd0 || tmo_flag !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b busy=%b kdrdy=%b iter=%0d mis=%0d tmo=%b", done, busy, aes_kdrdy, iter_cnt, mis_cnt, tmo_flag); end
        @(negedge CLK);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || aes_kdrdy !== 1'b0) begin errors++; $display("FAIL zero_after: done=%b busy=%b kdrdy=%b want 0/0/0", done, busy, aes_kdrdy); end
        core_rand = 0; core_lat = 2;
        k1 = {$urandom, $urandom, $urandom, $urandom};
        fill_exp(k1, 128'h5, 3, 0);
        key = k1; seed = 128'h5; n_iter = 10'd3; fault_mode = 2'd0; start = 1'b1;
        din_log.delete(); loads = 0; kd_bad = 0;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_state: busy=%b want 1", busy); end
        key = ~k1; seed = 128'h9; n_iter = 10'd7; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        c = 0;
        while (!done && c < 300) begin @(negedge CLK); c++; end
        checks++; if (!done || iter_cnt !== 10'd3 || mis_cnt !== 10'd0 || loads != 3 || aes_kin !== k1) begin errors++; $display("FAIL busy_ignore: done=%b iter=%0d mis=%0d loads=%0d want 1/3/0/3", done, iter_cnt, mis_cnt, loads); end
    endtask

    task automatic test_random();
        bit ok;
        int n, mis, first, bad;
        logic [1:0] fm;
        logic [127:0] k, s;
        core_rand = 1;
        for (int r = 0; r < 8; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom}; s = {$urandom, $urandom, $urandom, $urandom};
            n = $urandom_range(1, 8); fm = 2'($urandom_range(0, 3)); spur = 1'($urandom_range(0, 1));
            fill_exp(k, s, n, 35);
            mis = model_mis(k, s, n, first);
            run(k, s, n, fm, n * 40 + 50, ok);
            bad = 0;
            for (int i = 0; i < n; i++) if (i >= din_log.size() || din_log[i] !== mdl_din[i]) bad++;
            checks++; if (!ok || iter_cnt !== ITER_W'(n) || mis_cnt !== ITER_W'(mis)) begin errors++; $display("FAIL rand%0d_cnt: done=%b iter=%0d mis=%0d want 1/%0d/%0d", r, ok, iter_cnt, mis_cnt, n, mis); end
            checks++; if (fault_tag !== fm || tmo_flag !== 1'b0 || busy !== 1'b0 || aes_kin !== k) begin errors++; $display("FAIL rand%0d_status: tag=%0d tmo=%b busy=%b want %0d/0/0", r, fault_tag, tmo_flag, busy, fm); end
            checks++; if (bad != 0 || kd_bad != 0) begin errors++; $display("FAIL rand%0d_chain: wrong_din=%0d bad_kdrdy=%0d want 0/0", r, bad, kd_bad); end
`ifdef AES_TRACE_EN
            checks++; if (mis_seen !== (mis != 0) || (mis != 0 && mis_first !== ITER_W'(first))) begin errors++; $display("FAIL rand%0d_trace: seen=%b first=%0d want %0d/%0d", r, mis_seen, mis_first, mis != 0, first); end
`endif
        end
        spur = 0; core_rand = 0;
    endtask

    initial begin
        init_sbox();
        for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
        test_reset();
        test_fips();
        test_chain();
        test_corrupt();
        test_timeout();
        test_rst_mid();
        test_zero_and_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
